// File: rtl/wrr_table_arbiter.sv
// wrr_table_arbiter: weighted round-robin arbiter walking a programmable slot table
//   clk, rst          : clock and asynchronous active-high reset
//   enb               : advance enable, all state holds while low
//   pesos/selecciones : per-slot weight (consecutive grants) and queue id
//   table_len         : active slot count, 0 or above TABLE_SIZE selects the full table
//   buf_empty         : per-queue empty flags
//   selector/selector_enb : registered grant id and pop strobe
//   slot_idx/round_done   : registered current slot and wrap-to-slot-0 pulse
//   WRR_STRICT_PRIO_EN: when defined, a non-empty queue 0 preempts the table and freezes its position
module wrr_table_arbiter #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int TABLE_SIZE = 8,
    parameter int MAX_WEIGHT = 64,
    localparam int WEIGHT_BITS = $clog2(MAX_WEIGHT),
    parameter int SEL_BITS = $clog2(QUEUE_QUANTITY),
    parameter int IDX_BITS = $clog2(TABLE_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enb,
    input  logic [TABLE_SIZE*WEIGHT_BITS-1:0] pesos,
    input  logic [TABLE_SIZE*SEL_BITS-1:0]  selecciones,
    input  logic [IDX_BITS:0]               table_len,
    input  logic [QUEUE_QUANTITY-1:0]       buf_empty,
    output logic [SEL_BITS-1:0]             selector,
    output logic                            selector_enb,
    output logic [IDX_BITS-1:0]             slot_idx,
    output logic                            round_done
);
    localparam logic [IDX_BITS:0] FULL_LEN = TABLE_SIZE[IDX_BITS:0];
    localparam logic [SEL_BITS:0] QUEUE_LIM = QUEUE_QUANTITY[SEL_BITS:0];
    logic [WEIGHT_BITS-1:0] cnt, cnt_n, w;
    logic [SEL_BITS-1:0] q, selector_n;
    logic [IDX_BITS-1:0] slot_idx_n, nxt;
    logic [IDX_BITS:0] len, idx_inc;
    logic selector_enb_n, round_done_n, q_ok, elig, last, prio;
    assign len = (table_len == '0 || table_len > FULL_LEN) ? FULL_LEN : table_len;
    assign q = selecciones[slot_idx*SEL_BITS +: SEL_BITS];
    assign w = pesos[slot_idx*WEIGHT_BITS +: WEIGHT_BITS];
    // a slot index left beyond a shrunken table also wraps to 0 here
    assign idx_inc = {1'b0, slot_idx} + 1'b1;
    assign nxt = (idx_inc >= len) ? '0 : idx_inc[IDX_BITS-1:0];
    assign q_ok = {1'b0, q} < QUEUE_LIM;
    assign elig = (w != '0) && q_ok && !buf_empty[q] && (cnt < w);
    assign last = ({1'b0, cnt} + 1'b1) == {1'b0, w};
`ifdef WRR_STRICT_PRIO_EN
    assign prio = !buf_empty[0];
`else
    assign prio = 1'b0;
`endif
    always_comb begin
        selector_n = selector;
        selector_enb_n = 1'b0;
        slot_idx_n = slot_idx;
        cnt_n = cnt;
        round_done_n = 1'b0;
        if (enb && prio) begin
            selector_n = '0;
            selector_enb_n = 1'b1;
        end else if (enb) begin
            selector_n = elig ? q : selector;
            selector_enb_n = elig;
            cnt_n = (elig && !last) ? cnt + 1'b1 : '0;
            slot_idx_n = (elig && !last) ? slot_idx : nxt;
            round_done_n = !(elig && !last) && (nxt == '0);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            selector <= '0;
            selector_enb <= 1'b0;
            slot_idx <= '0;
            round_done <= 1'b0;
            cnt <= '0;
        end else begin
            selector <= selector_n;
            selector_enb <= selector_enb_n;
            slot_idx <= slot_idx_n;
            round_done <= round_done_n;
            cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_wrr_table_arbiter.sv
// tb_wrr_table_arbiter: directed self-checking bench for the table-driven WRR arbiter
module tb_wrr_table_arbiter;
    localparam int TS = 8, WB = 6, SB = 2, IB = 3;
    logic clk = 1'b0;
    logic rst, enb;
    logic [TS*WB-1:0] pesos, pesos_b;
    logic [TS*SB-1:0] selecciones, selecciones_b;
    logic [IB:0] table_len, table_len_b;
    logic [3:0] buf_empty;
    logic [2:0] buf_empty_b;
    logic [SB-1:0] selector, selector_b;
    logic selector_enb, selector_enb_b, round_done, round_done_b;
    logic [IB-1:0] slot_idx, slot_idx_b;
    int checks = 0;
    int passed = 0;
    always #5 clk = ~clk;
    wrr_table_arbiter #(.QUEUE_QUANTITY(4), .TABLE_SIZE(TS), .MAX_WEIGHT(64)) dut (
        .clk(clk), .rst(rst), .enb(enb), .pesos(pesos), .selecciones(selecciones),
        .table_len(table_len), .buf_empty(buf_empty), .selector(selector),
        .selector_enb(selector_enb), .slot_idx(slot_idx), .round_done(round_done)
    );
    wrr_table_arbiter #(.QUEUE_QUANTITY(3), .TABLE_SIZE(TS), .MAX_WEIGHT(64)) dut_b (
        .clk(clk), .rst(rst), .enb(enb), .pesos(pesos_b), .selecciones(selecciones_b),
        .table_len(table_len_b), .buf_empty(buf_empty_b), .selector(selector_b),
        .selector_enb(selector_enb_b), .slot_idx(slot_idx_b), .round_done(round_done_b)
    );
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic expect_a(input string tag, input int s, input int e, input int i, input int r);
        chk({tag, ".selector"}, selector, s);
        chk({tag, ".selector_enb"}, selector_enb, e);
        chk({tag, ".slot_idx"}, slot_idx, i);
        chk({tag, ".round_done"}, round_done, r);
    endtask
    task automatic expect_b(input string tag, input int s, input int e, input int i, input int r);
        chk({tag, ".b.selector"}, selector_b, s);
        chk({tag, ".b.selector_enb"}, selector_enb_b, e);
        chk({tag, ".b.slot_idx"}, slot_idx_b, i);
        chk({tag, ".b.round_done"}, round_done_b, r);
    endtask
    task automatic step(input string tag, input int s, input int e, input int i, input int r);
        @(posedge clk);
        #1;
        expect_a(tag, s, e, i, r);
    endtask
    initial begin
        rst = 1'b1;
        enb = 1'b1;
        pesos = '0;
        pesos[0+:WB] = 6'd2;
        pesos[WB+:WB] = 6'd1;
        pesos[2*WB+:WB] = 6'd3;
        selecciones = '0;
        selecciones[0+:SB] = 2'd1;
        selecciones[SB+:SB] = 2'd2;
        selecciones[2*SB+:SB] = 2'd3;
        table_len = 4'd3;
        buf_empty = 4'b0001;
        pesos_b = '0;
        pesos_b[0+:WB] = 6'd2;
        pesos_b[WB+:WB] = 6'd0;
        pesos_b[2*WB+:WB] = 6'd1;
        selecciones_b = selecciones;
        table_len_b = 4'd3;
        buf_empty_b = 3'b001;
        @(posedge clk);
        #1;
        expect_a("reset", 0, 0, 0, 0);
        expect_b("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step("walk1", 1, 1, 0, 0);
        step("walk2", 1, 1, 1, 0);
        step("walk3", 2, 1, 2, 0);
        step("walk4", 3, 1, 2, 0);
        step("walk5", 3, 1, 2, 0);
        step("walk6", 3, 1, 0, 1);
        step("walk7", 1, 1, 0, 0);
        step("walk8", 1, 1, 1, 0);
        buf_empty = 4'b0101;
        step("skip1", 1, 0, 2, 0);
        step("skip2", 3, 1, 2, 0);
        step("skip3", 3, 1, 2, 0);
        step("skip4", 3, 1, 0, 1);
        step("skip5", 1, 1, 0, 0);
        step("skip6", 1, 1, 1, 0);
        buf_empty = 4'b0001;
        step("pre_pause1", 2, 1, 2, 0);
        step("pre_pause2", 3, 1, 2, 0);
        enb = 1'b0;
        for (int k = 0; k < 4; k++) step("pause", 3, 0, 2, 0);
        enb = 1'b1;
        step("resume1", 3, 1, 2, 0);
        step("resume2", 3, 1, 0, 1);
        step("resume3", 1, 1, 0, 0);
        step("q0_pre1", 1, 1, 1, 0);
        step("q0_pre2", 2, 1, 2, 0);
        step("q0_pre3", 3, 1, 2, 0);
        buf_empty = 4'b0000;
`ifdef WRR_STRICT_PRIO_EN
        step("prio1", 0, 1, 2, 0);
        step("prio2", 0, 1, 2, 0);
        buf_empty = 4'b0001;
        step("prio3", 3, 1, 2, 0);
        step("prio4", 3, 1, 0, 1);
        step("prio5", 1, 1, 0, 0);
`else
        step("noprio1", 3, 1, 2, 0);
        step("noprio2", 3, 1, 0, 1);
        buf_empty = 4'b0001;
        step("noprio3", 1, 1, 0, 0);
        step("noprio4", 1, 1, 1, 0);
        step("noprio5", 2, 1, 2, 0);
`endif
        #2;
        rst = 1'b1;
        #1;
        expect_a("async_rst", 0, 0, 0, 0);
        expect_b("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst1", 1, 1, 0, 0);
        expect_b("post_rst1", 1, 1, 0, 0);
        buf_empty = 4'b0011;
        step("forfeit1", 1, 0, 1, 0);
        expect_b("zero_w1", 1, 1, 1, 0);
        buf_empty = 4'b0001;
        step("forfeit2", 2, 1, 2, 0);
        expect_b("zero_w2", 1, 0, 2, 0);
        table_len = 4'd1;
        step("shrink1", 3, 1, 2, 0);
        expect_b("bad_id", 1, 0, 0, 1);
        step("shrink2", 3, 1, 2, 0);
        expect_b("b_wrap", 1, 1, 0, 0);
        step("shrink3", 3, 1, 0, 1);
        step("len1_a", 1, 1, 0, 0);
        step("len1_b", 1, 1, 0, 1);
        step("len1_c", 1, 1, 0, 0);
        step("len1_d", 1, 1, 0, 1);
        table_len = 4'd3;
        buf_empty = 4'b1111;
        step("idle1", 1, 0, 1, 0);
        step("idle2", 1, 0, 2, 0);
        step("idle3", 1, 0, 0, 1);
        step("idle4", 1, 0, 1, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
